// File: rtl/pipeline_stall_controller_if.sv
// Control bundle between the hazard/MEM side of the pipeline and the stall controller.
// master drives the stall/branch/memory requests; slave is the controller that returns the stage controls.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             hz_load_stall;
  logic             id_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_enable;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             id_ex_enable;
  logic             id_ex_nop;
  logic             ex_mem_enable;
  logic             mem_wb_bubble;
  logic [1:0]       state;
  logic             fault;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output hz_load_stall, id_branch_taken, mem_req, mem_ready,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_nop,
           ex_mem_enable, mem_wb_bubble, state, fault, stall_count, flush_count
  );

  modport slave (
    input  hz_load_stall, id_branch_taken, mem_req, mem_ready,
    output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_nop,
           ex_mem_enable, mem_wb_bubble, state, fault, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/bubble/flush sequencer for the 5-stage pipeline; controls are combinational, state is registered.
// Optional statistics counters are built only when PIPE_STALL_STATS_EN is defined.
module pipeline_stall_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 64,
  parameter int CNT_W             = 16
) (
  input logic                        clk,
  input logic                        reset,
  pipeline_stall_controller_if.slave bus
);
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0]        LD_RELOAD   = 4'(LOAD_STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_LDSTALL = 2'b01,
    S_MEMWAIT = 2'b10,
    S_FAULT   = 2'b11
  } state_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic flush;
    logic id_ex;
    logic nop;
    logic ex_mem;
    logic bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = 7'b1101010;
  localparam ctrl_t CTRL_BUBBLE  = 7'b0001110;
  localparam ctrl_t CTRL_FREEZE  = 7'b0000001;
  localparam ctrl_t CTRL_FLUSH   = 7'b1111010;
  localparam ctrl_t CTRL_RESET   = 7'b0000101;

  state_e            state_q, state_d, eff_state;
  logic [3:0]        ld_cnt_q, ld_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              ret_ld_q, ret_ld_d;
  logic              fault_q, fault_d;
  logic              mem_wait;
  ctrl_t             ctrl;

  assign mem_wait = bus.mem_req & ~bus.mem_ready;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    ctrl       = CTRL_ADVANCE;
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ret_ld_d   = ret_ld_q;
    fault_d    = fault_q;
    eff_state  = state_q;

    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (state_q == S_FAULT) begin
      ctrl = CTRL_FREEZE;
    end else if (mem_wait) begin
      ctrl = CTRL_FREEZE;
      if (state_q == S_MEMWAIT) begin
        if (MEM_TIMEOUT != 0 && wait_cnt_q == TIMEOUT_CNT) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end else begin
        // ld_cnt stays frozen; a nonzero value means the load stall resumes afterwards.
        state_d    = S_MEMWAIT;
        wait_cnt_d = WAIT_W'(1);
        ret_ld_d   = (ld_cnt_q != 4'd0);
      end
    end else begin
      wait_cnt_d = '0;
      // The completion cycle of a memory wait behaves as the state it interrupted.
      if (state_q == S_MEMWAIT) begin
        eff_state = ret_ld_q ? S_LDSTALL : S_RUN;
      end
      if (eff_state == S_LDSTALL) begin
        ctrl     = CTRL_BUBBLE;
        ld_cnt_d = (ld_cnt_q != 4'd0) ? ld_cnt_q - 4'd1 : 4'd0;
        state_d  = (ld_cnt_q <= 4'd1) ? S_RUN : S_LDSTALL;
      end else if (bus.hz_load_stall) begin
        ctrl = CTRL_BUBBLE;
        if (LOAD_STALL_CYCLES > 1) begin
          ld_cnt_d = LD_RELOAD;
          state_d  = S_LDSTALL;
        end else begin
          state_d = S_RUN;
        end
      end else begin
        state_d = S_RUN;
        if (bus.id_branch_taken) begin
          ctrl = CTRL_FLUSH;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      ld_cnt_q   <= 4'd0;
      wait_cnt_q <= '0;
      ret_ld_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ret_ld_q   <= ret_ld_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.pc_enable     = ctrl.pc;
  assign bus.if_id_enable  = ctrl.if_id;
  assign bus.if_id_flush   = ctrl.flush;
  assign bus.id_ex_enable  = ctrl.id_ex;
  assign bus.id_ex_nop     = ctrl.nop;
  assign bus.ex_mem_enable = ctrl.ex_mem;
  assign bus.mem_wb_bubble = ctrl.bubble;
  assign bus.state         = state_q;
  assign bus.fault         = fault_q;

`ifdef PIPE_STALL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; reset cycles never count as stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctrl.pc && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ctrl.flush && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  assign bus.stall_count = '0;
  assign bus.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: three configurations share one stimulus stream and are
// compared every cycle against a queue-free behavioural model of the stall rules.
module tb_pipeline_stall_controller;
  localparam int CNT_W = 16;
`ifdef PIPE_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Control word order: pc, if_id, flush, id_ex, nop, ex_mem, bubble.
  localparam logic [6:0] K_ADV = 7'b1101010;
  localparam logic [6:0] K_BUB = 7'b0001110;
  localparam logic [6:0] K_FRZ = 7'b0000001;
  localparam logic [6:0] K_FLS = 7'b1111010;
  localparam logic [6:0] K_RST = 7'b0000101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hz = 1'b0, br = 1'b0, mq = 1'b0, mr = 1'b0;
  bit   chk_en = 1'b1;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  logic [6:0]       act_ctrl  [3];
  logic [1:0]       act_state [3];
  logic             act_fault [3];
  logic [CNT_W-1:0] act_scnt  [3];
  logic [CNT_W-1:0] act_fcnt  [3];

  pipeline_stall_controller_if #(.CNT_W(CNT_W)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_stall_controller #(
      .LOAD_STALL_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 2)),
      .MEM_TIMEOUT      (g == 2 ? 4 : 64),
      .CNT_W            (CNT_W)
    ) u_dut (
      .clk  (clk),
      .reset(rst),
      .bus  (ifs[g])
    );
    assign ifs[g].hz_load_stall   = hz;
    assign ifs[g].id_branch_taken = br;
    assign ifs[g].mem_req         = mq;
    assign ifs[g].mem_ready       = mr;
    assign act_ctrl[g]  = {ifs[g].pc_enable, ifs[g].if_id_enable, ifs[g].if_id_flush,
                           ifs[g].id_ex_enable, ifs[g].id_ex_nop, ifs[g].ex_mem_enable,
                           ifs[g].mem_wb_bubble};
    assign act_state[g] = ifs[g].state;
    assign act_fault[g] = ifs[g].fault;
    assign act_scnt[g]  = ifs[g].stall_count;
    assign act_fcnt[g]  = ifs[g].flush_count;
  end

  function automatic int lsc_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic int mt_of(input int k);
    return (k == 2) ? 4 : 64;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bubbles still owed, whether a memory wait is in progress and how long, sticky fault.
  int m_owed   [3] = '{0, 0, 0};
  bit m_wait   [3] = '{0, 0, 0};
  int m_waited [3] = '{0, 0, 0};
  bit m_flt    [3] = '{0, 0, 0};
  int m_scnt   [3] = '{0, 0, 0};
  int m_fcnt   [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [6:0] exp_ctrl;
        logic [1:0] exp_state;
        if (rst)                  exp_ctrl = K_RST;
        else if (m_flt[k])        exp_ctrl = K_FRZ;
        else if (mq && !mr)       exp_ctrl = K_FRZ;
        else if (m_owed[k] > 0)   exp_ctrl = K_BUB;
        else if (hz)              exp_ctrl = K_BUB;
        else if (br)              exp_ctrl = K_FLS;
        else                      exp_ctrl = K_ADV;
        exp_state = m_flt[k] ? 2'd3 : (m_wait[k] ? 2'd2 : ((m_owed[k] > 0) ? 2'd1 : 2'd0));

        check($sformatf("dut%0d.ctrl", k),  32'(act_ctrl[k]),  32'(exp_ctrl));
        check($sformatf("dut%0d.state", k), 32'(act_state[k]), 32'(exp_state));
        check($sformatf("dut%0d.fault", k), 32'(act_fault[k]), 32'(m_flt[k]));
        check($sformatf("dut%0d.stall_count", k), 32'(act_scnt[k]), STATS ? m_scnt[k] : 0);
        check($sformatf("dut%0d.flush_count", k), 32'(act_fcnt[k]), STATS ? m_fcnt[k] : 0);

        if (rst) begin
          m_owed[k] = 0; m_wait[k] = 0; m_waited[k] = 0; m_flt[k] = 0;
          m_scnt[k] = 0; m_fcnt[k] = 0;
        end else begin
          if (!m_flt[k]) begin
            if (mq && !mr) begin
              if (!m_wait[k]) begin
                m_wait[k] = 1; m_waited[k] = 1;
              end else if (mt_of(k) != 0 && m_waited[k] == mt_of(k)) begin
                m_flt[k] = 1; m_wait[k] = 0;
              end else begin
                m_waited[k]++;
              end
            end else begin
              m_wait[k] = 0; m_waited[k] = 0;
              if (m_owed[k] > 0) m_owed[k]--;
              else if (hz)       m_owed[k] = lsc_of(k) - 1;
            end
          end
          if (exp_ctrl[6] == 1'b0 && m_scnt[k] < (1 << CNT_W) - 1) m_scnt[k]++;
          if (exp_ctrl[4] == 1'b1 && m_fcnt[k] < (1 << CNT_W) - 1) m_fcnt[k]++;
        end
      end
    end
  end

  // One clock cycle: inputs change just after the rising edge; returns just after the falling edge.
  task automatic go(input logic r, input logic h, input logic b, input logic q, input logic y);
    @(posedge clk); #1;
    rst = r; hz = h; br = b; mq = q; mr = y;
    @(negedge clk); #1;
  endtask

  int nb, nf;

  task automatic tally();
    if (act_ctrl[1] == K_BUB) nb++;
    if (act_ctrl[1] == K_FRZ) nf++;
  endtask

  initial begin
    // Reset for two cycles, then release with all inputs low.
    go(1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0);
    check("pin_reset_ctrl", 32'(act_ctrl[0]), 32'(K_RST));
    go(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pin_idle_state%0d", k), 32'(act_state[k]), 0);
      check($sformatf("pin_idle_ctrl%0d", k),  32'(act_ctrl[k]),  32'(K_ADV));
      check($sformatf("pin_idle_fault%0d", k), 32'(act_fault[k]), 0);
    end

    // Single-cycle load stall on the LOAD_STALL_CYCLES=1 instance.
    go(0, 1, 0, 0, 0);
    check("pin_ld1_bubble", 32'(act_ctrl[0]), 32'(K_BUB));
    go(0, 0, 0, 0, 0);
    check("pin_ld1_advance", 32'(act_ctrl[0]), 32'(K_ADV));
    check("pin_ld1_stall_count", 32'(act_scnt[0]), STATS ? 1 : 0);
    repeat (3) go(0, 0, 0, 0, 0);

    // Three-cycle load stall interrupted by a memory wait (instance 1).
    nb = 0; nf = 0;
    go(0, 1, 0, 0, 0); tally();
    check("pin_lm_state_c0", 32'(act_state[1]), 0);
    go(0, 0, 0, 1, 0); tally();
    check("pin_lm_state_c1", 32'(act_state[1]), 1);
    go(0, 0, 0, 1, 0); tally();
    check("pin_lm_state_c2", 32'(act_state[1]), 2);
    repeat (3) begin go(0, 0, 0, 1, 0); tally(); end
    go(0, 0, 0, 0, 0); tally();
    check("pin_lm_completion_ctrl", 32'(act_ctrl[1]), 32'(K_BUB));
    check("pin_lm_completion_state", 32'(act_state[1]), 2);
    go(0, 0, 0, 0, 0); tally();
    check("pin_lm_state_c7", 32'(act_state[1]), 1);
    go(0, 0, 0, 0, 0); tally();
    check("pin_lm_state_c8", 32'(act_state[1]), 0);
    check("pin_lm_ctrl_c8", 32'(act_ctrl[1]), 32'(K_ADV));
    check("pin_lm_bubbles", nb, 3);
    check("pin_lm_freezes", nf, 5);

    // Branch together with a load stall, then a branch alone (instance 0).
    go(0, 1, 1, 0, 0);
    check("pin_br_with_stall_flush", 32'(ifs[0].if_id_flush), 0);
    check("pin_br_with_stall_ctrl", 32'(act_ctrl[0]), 32'(K_BUB));
    go(0, 0, 1, 0, 0);
    check("pin_br_alone_ctrl", 32'(act_ctrl[0]), 32'(K_FLS));
    go(0, 0, 0, 0, 0);
    check("pin_br_flush_count", 32'(act_fcnt[0]), STATS ? 1 : 0);

    // Memory timeout on the MEM_TIMEOUT=4 instance.
    go(1, 0, 0, 0, 0);
    repeat (5) go(0, 0, 0, 1, 0);
    check("pin_to_state_wait", 32'(act_state[2]), 2);
    go(0, 0, 0, 1, 0);
    check("pin_to_state_fault", 32'(act_state[2]), 3);
    check("pin_to_fault", 32'(act_fault[2]), 1);
    check("pin_to_ctrl", 32'(act_ctrl[2]), 32'(K_FRZ));
    go(0, 0, 0, 1, 1);
    check("pin_to_sticky_ctrl", 32'(act_ctrl[2]), 32'(K_FRZ));
    check("pin_to_sticky_fault", 32'(act_fault[2]), 1);
    go(1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0);
    check("pin_to_reset_state", 32'(act_state[2]), 0);
    check("pin_to_reset_fault", 32'(act_fault[2]), 0);

    // Randomized traffic, including occasional resets mid-stall or mid-wait.
    for (int i = 0; i < 3000; i++) begin
      go($urandom_range(0, 149) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
         $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
